// File: rtl/ground_cmd_encoder.sv
// Ground/ceiling display command issuer: queues sprite updates, emits one command word per cycle, closes frames with a swap.
// Optional macro CMD_COORD_CLAMP_EN saturates coordinate payloads (types 010/011/100) to 639 at queue entry.
module ground_cmd_encoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_sub_comp,
    input  logic [4:0]  req_child,
    input  logic [2:0]  req_type,
    input  logic [12:0] req_msg,
    input  logic        frame_end,
    output logic [31:0] writedata,
    output logic        disp_buf,
    output logic        busy,
    output logic        frame_overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [5:0]  sub_comp;
        logic [4:0]  child;
        logic [2:0]  typ;
        logic [12:0] msg;
    } req_t;

    typedef enum logic [1:0] {IDLE, SEND, SWAP} state_t;

    req_t        mem [FIFO_DEPTH];
    req_t        head;
    req_t        req_in;
    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic        fifo_empty, fifo_full, push, pop;
    logic        swap_pending, swap_hold;
    logic        swap_pending_next, swap_hold_next, disp_buf_next, overrun_next, busy_next;
    logic [31:0] writedata_next;
    state_t      state;

    function automatic req_t clamp_req(input req_t r);
        req_t o;
        o = r;
`ifdef CMD_COORD_CLAMP_EN
        if (r.typ == 3'b010 || r.typ == 3'b011 || r.typ == 3'b100) begin
            o.msg = {3'b000, (r.msg[9:0] > 10'd639) ? 10'd639 : r.msg[9:0]};
        end
`endif
        return o;
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Ready stays low through the SWAP cycle so next-frame requests start strictly after it.
    assign req_ready  = !fifo_full && !swap_pending && !swap_hold;
    assign push       = req_valid && req_ready;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign req_in     = clamp_req('{sub_comp: req_sub_comp, child: req_child,
                                    typ: req_type, msg: req_msg});

    always_comb begin
        state = IDLE;
        if (!fifo_empty) begin
            state = SEND;
        end else if (swap_pending) begin
            state = SWAP;
        end
    end

    always_comb begin
        writedata_next    = '0;
        disp_buf_next     = disp_buf;
        swap_pending_next = swap_pending;
        swap_hold_next    = 1'b0;
        overrun_next      = frame_overrun;
        pop               = 1'b0;
        case (state)
            SEND: begin
                pop            = 1'b1;
                writedata_next = {head.sub_comp, head.child, 4'b0001, head.typ, ~disp_buf, head.msg};
            end
            SWAP: begin
                writedata_next    = {11'b0, 4'b1111, 3'b000, ~disp_buf, 13'b0};
                disp_buf_next     = ~disp_buf;
                swap_pending_next = 1'b0;
                swap_hold_next    = 1'b1;
            end
            default: ;
        endcase
        // A second frame_end while a swap is still owed is dropped and flagged.
        if (frame_end) begin
            if (swap_pending) begin
                overrun_next = 1'b1;
            end else begin
                swap_pending_next = 1'b1;
            end
        end
        wr_ptr_next = push ? wr_ptr + (AW+1)'(1) : wr_ptr;
        rd_ptr_next = pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;
        busy_next   = (wr_ptr_next != rd_ptr_next) || swap_pending_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            writedata     <= '0;
            disp_buf      <= 1'b0;
            swap_pending  <= 1'b0;
            swap_hold     <= 1'b0;
            frame_overrun <= 1'b0;
            busy          <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr_next;
            rd_ptr        <= rd_ptr_next;
            writedata     <= writedata_next;
            disp_buf      <= disp_buf_next;
            swap_pending  <= swap_pending_next;
            swap_hold     <= swap_hold_next;
            frame_overrun <= overrun_next;
            busy          <= busy_next;
        end
    end

    // Queue storage carries data only; the pointers alone define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= req_in;
        end
    end
endmodule

// File: tb/tb_ground_cmd_encoder.sv
// Randomized bench for ground_cmd_encoder against a queue-based reference of the command stream.
module tb_ground_cmd_encoder;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset, req_valid, frame_end;
    logic        req_ready, disp_buf, busy, frame_overrun;
    logic [5:0]  req_sub_comp;
    logic [4:0]  req_child;
    logic [2:0]  req_type;
    logic [12:0] req_msg;
    logic [31:0] writedata;

    ground_cmd_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_sub_comp(req_sub_comp), .req_child(req_child), .req_type(req_type),
        .req_msg(req_msg), .frame_end(frame_end), .writedata(writedata),
        .disp_buf(disp_buf), .busy(busy), .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sub_comp;
        int child;
        int typ;
        int msg;
    } req_s;

    req_s        q[$];
    logic [31:0] m_wd;
    logic        m_disp, m_busy, m_ovr, m_pend, m_hold;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_msg(input int typ, input int msg);
`ifdef CMD_COORD_CLAMP_EN
        if (typ >= 2 && typ <= 4) begin
            int v;
            v = msg % 1024;
            if (v > 639) v = 639;
            return v;
        end
`endif
        return msg;
    endfunction

    function automatic logic [31:0] upd_word(input req_s r, input int bs);
        int unsigned w;
        w = r.sub_comp * (1 << 26) + r.child * (1 << 21) + (1 << 17)
          + r.typ * (1 << 14) + bs * (1 << 13) + r.msg;
        return 32'(w);
    endfunction

    task automatic model_reset();
        q.delete();
        m_wd = '0; m_disp = 1'b0; m_busy = 1'b0; m_ovr = 1'b0; m_pend = 1'b0; m_hold = 1'b0;
    endtask

    task automatic drive(input bit v, input int sub, input int ch, input int typ,
                         input int msg, input bit fe);
        req_valid    = v;
        req_sub_comp = 6'(sub);
        req_child    = 5'(ch);
        req_type     = 3'(typ);
        req_msg      = 13'(msg);
        frame_end    = fe;
    endtask

    task automatic cycle(input bit chk);
        bit   ready, acc, was_pend;
        req_s r;
        ready = (q.size() < DEPTH) && !m_pend && !m_hold;
        if (chk) begin
            check("writedata", writedata, m_wd);
            check("disp_buf", 32'(disp_buf), 32'(m_disp));
            check("busy", 32'(busy), 32'(m_busy));
            check("frame_overrun", 32'(frame_overrun), 32'(m_ovr));
            check("req_ready", 32'(req_ready), 32'(ready));
        end
        acc = req_valid && ready;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            was_pend = m_pend;
            m_hold   = 1'b0;
            if (q.size() > 0) begin
                r    = q.pop_front();
                m_wd = upd_word(r, m_disp ? 0 : 1);
            end else if (m_pend) begin
                m_wd   = 32'h001E_0000 + (m_disp ? 32'h0 : 32'h2000);
                m_disp = !m_disp;
                m_pend = 1'b0;
                m_hold = 1'b1;
            end else begin
                m_wd = '0;
            end
            if (acc) begin
                r.sub_comp = int'(req_sub_comp);
                r.child    = int'(req_child);
                r.typ      = int'(req_type);
                r.msg      = ref_msg(int'(req_type), int'(req_msg));
                q.push_back(r);
            end
            if (frame_end) begin
                if (was_pend) m_ovr = 1'b1;
                else m_pend = 1'b1;
            end
            m_busy = (q.size() > 0) || m_pend;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            cycle(1);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        cycle(0);
        cycle(1);
        reset = 1'b0;
        idle(3);

        // Two frames with the same request: back buffer alternates.
        for (int f = 0; f < 2; f++) begin
            drive(1, 6'h0F, 0, 2, 13'h064, 0); cycle(1);
            drive(0, 0, 0, 0, 0, 1);           cycle(1);
            idle(4);
            check("disp_after_frame", 32'(disp_buf), (f == 0) ? 32'd1 : 32'd0);
        end

        // Request and frame_end in the same cycle.
        drive(1, 6'h21, 5'h3, 1, 13'h1ABC, 1); cycle(1);
        idle(4);

        // Back-to-back burst of DEPTH+1 requests, then close the frame.
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1, $urandom_range(63), $urandom_range(31), $urandom_range(7), $urandom_range(8191), 0);
            cycle(1);
        end
        drive(0, 0, 0, 0, 0, 1); cycle(1);
        idle(6);

        // Four requests then two frame_end pulses: one swap, sticky overrun.
        for (int i = 0; i < 4; i++) begin
            drive(1, i + 1, i, 3, 100 * i, 0);
            cycle(1);
        end
        drive(0, 0, 0, 0, 0, 1); cycle(1);
        drive(0, 0, 0, 0, 0, 1); cycle(1);
        idle(8);
        check("overrun_sticky", 32'(frame_overrun), 32'd1);
        reset = 1'b1; drive(0, 0, 0, 0, 0, 0); cycle(1);
        reset = 1'b0;
        check("overrun_cleared", 32'(frame_overrun), 32'd0);
        idle(2);

        // Coordinate payload above the visible width.
        drive(1, 6'h0F, 0, 2, 13'h03FF, 0); cycle(1);
        drive(0, 0, 0, 0, 0, 0);            cycle(1);
`ifdef CMD_COORD_CLAMP_EN
        check("clamp_msg", 32'(writedata[12:0]), 32'h27F);
`else
        check("clamp_msg", 32'(writedata[12:0]), 32'h3FF);
`endif
        idle(3);

        // Random traffic with occasional mid-stream resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(199) == 0);
            drive($urandom_range(9) < 6, $urandom_range(63), $urandom_range(31),
                  $urandom_range(7), $urandom_range(8191), $urandom_range(19) == 0);
            cycle(1);
        end
        reset = 1'b0;
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
